// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the
// physical RAM port.
interface ram_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              a_req;
   logic              a_we;
   logic              a_lock;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_gnt;
   logic              a_rvalid;
   logic [DATA_W-1:0] a_rdata;

   logic              b_req;
   logic              b_we;
   logic              b_lock;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_gnt;
   logic              b_rvalid;
   logic [DATA_W-1:0] b_rdata;

   logic [ADDR_W-1:0] phy_ram_addr;
   logic [DATA_W-1:0] phy_ram_write;
   logic              phy_ram_op;
   logic [DATA_W-1:0] phy_ram_read;

   modport master (
      output a_req, a_we, a_lock, a_addr, a_wdata,
      output b_req, b_we, b_lock, b_addr, b_wdata,
      output phy_ram_read,
      input  a_gnt, a_rvalid, a_rdata,
      input  b_gnt, b_rvalid, b_rdata,
      input  phy_ram_addr, phy_ram_write, phy_ram_op
   );

   modport slave (
      input  a_req, a_we, a_lock, a_addr, a_wdata,
      input  b_req, b_we, b_lock, b_addr, b_wdata,
      input  phy_ram_read,
      output a_gnt, a_rvalid, a_rdata,
      output b_gnt, b_rvalid, b_rdata,
      output phy_ram_addr, phy_ram_write, phy_ram_op
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin RAM arbiter with bus lock, starvation guard
// and fixed-latency read return.
module ram_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int READ_LATENCY = 1,
   parameter int MAX_WAIT     = 4
) (
   input logic               clk,
   input logic               rst,
   ram_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_A    = 2'd1,
      OWN_B    = 2'd2
   } owner_e;

   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   owner_e owner_q;
   owner_e owner_d;
   logic   last_b;
   logic   last_b_d;

   logic [3:0] wait_a;
   logic [3:0] wait_b;
   logic       force_a;
   logic       force_b;
   logic       gnt_a;
   logic       gnt_b;
   logic       rd_push;

   logic [READ_LATENCY-1:0] tag_v;
   logic [READ_LATENCY-1:0] tag_b;
   logic                    ret_a;
   logic                    ret_b;

   logic [DATA_W-1:0] rdata_a_q;
   logic [DATA_W-1:0] rdata_b_q;

   logic [ADDR_W-1:0] phy_addr;
   logic [DATA_W-1:0] phy_wdata;
   logic              phy_op;

   function automatic logic [3:0] wait_next(
      input logic       req,
      input logic       gnt,
      input logic [3:0] cnt
   );
      if (!req || gnt) return 4'd0;
      if (cnt == WAIT_MAX) return cnt;
      return cnt + 4'd1;
   endfunction

   assign force_a = bus.a_req && (wait_a == WAIT_MAX);
   assign force_b = bus.b_req && (wait_b == WAIT_MAX);

   always_comb begin
      gnt_a    = 1'b0;
      gnt_b    = 1'b0;
      owner_d  = OWN_NONE;
      last_b_d = last_b;
      if (rst) begin
         gnt_a = 1'b0;
         gnt_b = 1'b0;
      end else if (force_a && force_b) begin
         gnt_a = last_b;
         gnt_b = !last_b;
      end else if (force_a) begin
         gnt_a = 1'b1;
      end else if (force_b) begin
         gnt_b = 1'b1;
      end else if (owner_q == OWN_A && bus.a_req) begin
         gnt_a = 1'b1;
      end else if (owner_q == OWN_B && bus.b_req) begin
         gnt_b = 1'b1;
      end else if (bus.a_req && bus.b_req) begin
         gnt_a = last_b;
         gnt_b = !last_b;
      end else begin
         gnt_a = bus.a_req;
         gnt_b = bus.b_req;
      end

      // Without a grant the owner cannot be requesting, so the lock drops.
      if (gnt_a) begin
         owner_d  = bus.a_lock ? OWN_A : OWN_NONE;
         last_b_d = 1'b0;
      end else if (gnt_b) begin
         owner_d  = bus.b_lock ? OWN_B : OWN_NONE;
         last_b_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWN_NONE;
         last_b  <= 1'b1;
         wait_a  <= 4'd0;
         wait_b  <= 4'd0;
      end else begin
         owner_q <= owner_d;
         last_b  <= last_b_d;
         wait_a  <= wait_next(bus.a_req, gnt_a, wait_a);
         wait_b  <= wait_next(bus.b_req, gnt_b, wait_b);
      end
   end

   always_comb begin
      phy_addr  = '0;
      phy_wdata = '0;
      phy_op    = 1'b0;
      unique case (1'b1)
         gnt_a: begin
            phy_addr  = bus.a_addr;
            phy_wdata = bus.a_we ? bus.a_wdata : '0;
            phy_op    = bus.a_we;
         end
         gnt_b: begin
            phy_addr  = bus.b_addr;
            phy_wdata = bus.b_we ? bus.b_wdata : '0;
            phy_op    = bus.b_we;
         end
         default: begin
            phy_addr  = '0;
            phy_wdata = '0;
            phy_op    = 1'b0;
         end
      endcase
   end

   assign rd_push = (gnt_a && !bus.a_we) || (gnt_b && !bus.b_we);

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v <= '0;
         tag_b <= '0;
      end else begin
         for (int i = READ_LATENCY - 1; i > 0; i--) begin
            tag_v[i] <= tag_v[i-1];
            tag_b[i] <= tag_b[i-1];
         end
         tag_v[0] <= rd_push;
         tag_b[0] <= gnt_b;
      end
   end

   assign ret_a = !rst && tag_v[READ_LATENCY-1] && !tag_b[READ_LATENCY-1];
   assign ret_b = !rst && tag_v[READ_LATENCY-1] && tag_b[READ_LATENCY-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         if (ret_a) rdata_a_q <= bus.phy_ram_read;
         if (ret_b) rdata_b_q <= bus.phy_ram_read;
      end
   end

   // Returning data bypasses the hold register so rvalid and rdata align.
   assign bus.a_rdata  = rst ? '0 : (ret_a ? bus.phy_ram_read : rdata_a_q);
   assign bus.b_rdata  = rst ? '0 : (ret_b ? bus.phy_ram_read : rdata_b_q);
   assign bus.a_rvalid = ret_a;
   assign bus.b_rvalid = ret_b;
   assign bus.a_gnt    = gnt_a;
   assign bus.b_gnt    = gnt_b;

   assign bus.phy_ram_addr  = phy_addr;
   assign bus.phy_ram_write = phy_wdata;
   assign bus.phy_ram_op    = phy_op;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single physical RAM port between two requesters: port A (CPU load/store) and port B (serial/DMA engine that moves buffer words to and from RAM).
- Sits between the requesters and the physical RAM interface (phy_ram_addr/phy_ram_write/phy_ram_op/phy_ram_read).
- Round-robin arbitration with an optional bus lock for multi-word bursts and a starvation guard.
- Returns read data to the owning port after a fixed RAM read latency.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- READ_LATENCY, 1, cycles from accepted read to valid phy_ram_read; range 1..4.
- MAX_WAIT, 4, cycles a requesting port may be refused before it gets forced priority; range 1..15.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- a_req, b_req  in  1  port requests a transfer this cycle.
- a_we, b_we  in  1  1 = write, 0 = read.
- a_lock, b_lock  in  1  keep ownership after this transfer.
- a_addr, b_addr  in  ADDR_W  word address.
- a_wdata, b_wdata  in  DATA_W  write data.
- a_gnt, b_gnt  out  1  transfer accepted this cycle.
- a_rvalid, b_rvalid  out  1  read data valid.
- a_rdata, b_rdata  out  DATA_W  read data.
- phy_ram_addr  out  ADDR_W  RAM address.
- phy_ram_write  out  DATA_W  RAM write data.
- phy_ram_op  out  1  1 = write strobe, 0 = read/idle.
- phy_ram_read  in  DATA_W  RAM read data.

Behaviour:
- Reset:
  - gnt, rvalid = 0; rdata = 0.
  - phy_ram_addr = 0, phy_ram_write = 0, phy_ram_op = 0.
  - Read-tag pipeline cleared; wait counters = 0; owner = NONE; last_winner = B, so A wins the first tie.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced afterwards.
- Grant is combinational in the same cycle as the request. A transfer completes when req & gnt; the port holds its signals until granted. At most one gnt is high per cycle.
- Selection order:
  1. Forced priority: a requesting port whose wait_cnt == MAX_WAIT wins, overriding lock. If both qualify, the port != last_winner wins.
  2. Lock: if owner is X and X is requesting, X wins.
  3. Only one port requesting: that port wins.
  4. Both requesting: the port != last_winner wins.
- On a grant to X:
  - last_winner <= X.
  - owner <= X if x_lock, else NONE.
  - If X does not request while it is owner, owner <= NONE (lock drops).
- Wait counters: a port with req & !gnt increments its counter, saturating at MAX_WAIT. The counter clears on grant or when req is low.
- Physical drive:
  - Granted write: phy_ram_addr = addr, phy_ram_write = wdata, phy_ram_op = 1.
  - Granted read: phy_ram_addr = addr, phy_ram_op = 0.
  - No grant: phy_ram_addr = 0, phy_ram_op = 0, phy_ram_write = 0.
- Read return:
  - Each granted read pushes a tag {valid, port} into a READ_LATENCY-deep shift register.
  - When the tag exits, phy_ram_read is sampled into that port's rdata and its rvalid pulses for one cycle.
  - rdata holds its value until the next return to the same port.
  - Back-to-back reads from alternating ports return in issue order, one per cycle. Writes push an invalid tag.
- Address space:
  - Transparent; MMIO decoding stays downstream.
  - Addresses with bit 15 set are forwarded unchanged.
- Arithmetic: wait_cnt is 4 bits, saturating. All comparisons are unsigned.

Test Plan:
- Single port: reset, then A read at 0x0010 with the RAM model returning 0x1234 (READ_LATENCY=1) -> a_gnt the same cycle, phy_ram_op=0, a_rvalid=1 and a_rdata=0x1234 one cycle later; b_rvalid stays 0.
- Simultaneous writes:
  - Stimulus: A and B both request a write every cycle from reset; A writes 0x1111 to 0x0020, B writes 0x2222 to 0x0030.
  - Required: grants alternate A,B,A,B; each cycle phy_ram_op=1 with the matching addr/data.
- Lock burst: B holds b_lock=1 for 3 reads at 0x40..0x42 while A requests continuously, MAX_WAIT=4 -> B is granted 3 consecutive cycles, then A; B's three rvalids return in order.
- Starvation: B holds lock indefinitely while A requests, MAX_WAIT=2 -> A is refused for 2 cycles, granted on the 3rd cycle, then B regains the port.
- Latency 3: READ_LATENCY=3, read A@0x5 then B@0x6 on consecutive cycles -> a_rvalid at t+3, b_rvalid at t+4, each with the correct data.
- Reset mid-flight: assert rst one cycle after a granted read with READ_LATENCY=2 -> no rvalid follows; all outputs are 0 during reset and the first tie after reset goes to A.
